// File: rtl/matrix_job_scheduler.sv
// Matrix job scheduler: buffers matrix-multiply descriptors written by the CPU
// and walks the accelerator through each one as a Wishbone master
// (program, start, poll, clear, retire), raising a sticky interrupt per job.
module matrix_job_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_DIM    = 8,
    parameter int POLL_GAP   = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    output logic        irq
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int GAP_W  = $clog2(POLL_GAP + 1);
    localparam int POLL_W = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_A     = 4'd1;
    localparam logic [3:0] S_WR_B     = 4'd2;
    localparam logic [3:0] S_WR_C     = 4'd3;
    localparam logic [3:0] S_WR_M     = 4'd4;
    localparam logic [3:0] S_WR_N     = 4'd5;
    localparam logic [3:0] S_WR_P     = 4'd6;
    localparam logic [3:0] S_WR_START = 4'd7;
    localparam logic [3:0] S_GAP      = 4'd8;
    localparam logic [3:0] S_POLL     = 4'd9;
    localparam logic [3:0] S_WR_CLEAR = 4'd10;
    localparam logic [3:0] S_RETIRE   = 4'd11;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [23:0] dims;
    } desc_t;

    logic              ack_q;
    logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic [23:0]       dims_q, dims_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        state_q, state_d;
    logic              stb_q, stb_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              job_to_q, job_to_d;
    logic              reject_q, reject_d;
    logic              tmo_q, tmo_d;
    logic              irq_q, irq_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    desc_t             mem_q [FIFO_DEPTH];

    logic [4:0]  adr;
    logic        wr_ev, full, empty, dims_ok, push_req, push_ok, pop, is_bus;
    logic [31:0] bus_adr, bus_dat;
    logic        bus_we;
    desc_t       head;
    logic        unused_ok;

    assign adr      = s_adr_i[4:0];
    assign wr_ev    = ack_q && s_we_i;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign dims_ok  = (dims_q[7:0] != 8'd0) && (dims_q[15:8] != 8'd0) && (dims_q[23:16] != 8'd0)
                   && (dims_q[7:0] <= MAX_DIM_B) && (dims_q[15:8] <= MAX_DIM_B)
                   && (dims_q[23:16] <= MAX_DIM_B);
    assign push_req = wr_ev && (adr == 5'h10);
    assign push_ok  = push_req && !full && dims_ok;
    assign pop      = (state_q == S_RETIRE);
    assign head     = mem_q[rd_ptr_q];
    assign unused_ok = ^s_adr_i[31:5];

    // Staging registers written by the CPU in the ack cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        dims_d = dims_q;
        if (wr_ev) begin
            case (adr)
                5'h00:   a_d    = s_dat_i;
                5'h04:   b_d    = s_dat_i;
                5'h08:   c_d    = s_dat_i;
                5'h0C:   dims_d = s_dat_i[23:0];
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_ok ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    // Master transaction contents for the current bus state.
    always_comb begin
        is_bus  = 1'b1;
        bus_we  = 1'b1;
        bus_adr = 32'h0;
        bus_dat = 32'h0;
        case (state_q)
            S_WR_A:     begin bus_adr = 32'h04; bus_dat = head.a; end
            S_WR_B:     begin bus_adr = 32'h08; bus_dat = head.b; end
            S_WR_C:     begin bus_adr = 32'h0C; bus_dat = head.c; end
            S_WR_M:     begin bus_adr = 32'h10; bus_dat = {24'h0, head.dims[7:0]}; end
            S_WR_N:     begin bus_adr = 32'h12; bus_dat = {24'h0, head.dims[15:8]}; end
            S_WR_P:     begin bus_adr = 32'h14; bus_dat = {24'h0, head.dims[23:16]}; end
            S_WR_START: begin bus_adr = 32'h00; bus_dat = 32'h1; end
            S_POLL:     begin bus_adr = 32'h16; bus_we = 1'b0; end
            S_WR_CLEAR: begin bus_adr = 32'h00; bus_dat = 32'h0; end
            default:    is_bus = 1'b0;
        endcase
    end

    // Job sequencer, strobe handshake, status flags and counters.
    always_comb begin
        state_d    = state_q;
        stb_d      = stb_q;
        gap_d      = gap_q;
        poll_d     = poll_q;
        job_to_d   = job_to_q;
        done_cnt_d = done_cnt_q;
        err_cnt_d  = err_cnt_q;
        reject_d   = reject_q;
        tmo_d      = tmo_q;
        irq_d      = irq_q;

        // CPU clears go first so that a set in the same cycle wins.
        if (wr_ev && adr == 5'h1C) begin
            if (s_dat_i[0]) irq_d = 1'b0;
            if (s_dat_i[1]) begin
                reject_d = 1'b0;
                tmo_d    = 1'b0;
            end
        end
        if (push_req && !push_ok) reject_d = 1'b1;

        if (state_q == S_WR_START) begin
            poll_d   = '0;
            job_to_d = 1'b0;
        end

        // A bus state idles one cycle with strobe low, then holds strobe until ack.
        if (is_bus) begin
            if (!stb_q) begin
                stb_d = 1'b1;
            end else if (m_ack_i) begin
                stb_d = 1'b0;
                case (state_q)
                    S_WR_A:     state_d = S_WR_B;
                    S_WR_B:     state_d = S_WR_C;
                    S_WR_C:     state_d = S_WR_M;
                    S_WR_M:     state_d = S_WR_N;
                    S_WR_N:     state_d = S_WR_P;
                    S_WR_P:     state_d = S_WR_START;
                    S_WR_START: begin state_d = S_GAP; gap_d = '0; end
                    S_POLL: begin
                        if (m_dat_i == 32'd2) begin
                            state_d = S_WR_CLEAR;
                        end else begin
                            poll_d = poll_q + POLL_W'(1);
                            if (poll_d == POLL_W'(TIMEOUT)) begin
                                tmo_d     = 1'b1;
                                job_to_d  = 1'b1;
                                err_cnt_d = err_cnt_q + 8'd1;
                                state_d   = S_WR_CLEAR;
                            end else begin
                                gap_d   = '0;
                                state_d = S_GAP;
                            end
                        end
                    end
                    default:    state_d = S_RETIRE;
                endcase
            end
        end else begin
            case (state_q)
                S_IDLE: if (!empty) state_d = S_WR_A;
                S_GAP: begin
                    if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL;
                    else                               gap_d   = gap_q + GAP_W'(1);
                end
                S_RETIRE: begin
                    if (!job_to_q) done_cnt_d = done_cnt_q + 16'd1;
                    irq_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            ack_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            dims_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            stb_q      <= 1'b0;
            gap_q      <= '0;
            poll_q     <= '0;
            job_to_q   <= 1'b0;
            reject_q   <= 1'b0;
            tmo_q      <= 1'b0;
            irq_q      <= 1'b0;
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            ack_q      <= s_stb_i && !ack_q;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            dims_q     <= dims_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            stb_q      <= stb_d;
            gap_q      <= gap_d;
            poll_q     <= poll_d;
            job_to_q   <= job_to_d;
            reject_q   <= reject_d;
            tmo_q      <= tmo_d;
            irq_q      <= irq_d;
            done_cnt_q <= done_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Descriptor storage; written on accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; count and pointers alone define validity.
        if (push_ok) mem_q[wr_ptr_q] <= '{a: a_q, b: b_q, c: c_q, dims: dims_q};
    end

    // CPU read mux, driven only during a read ack.
    always_comb begin
        s_dat_o = 32'h0;
        if (ack_q && !s_we_i) begin
            case (adr)
                5'h00:   s_dat_o = a_q;
                5'h04:   s_dat_o = b_q;
                5'h08:   s_dat_o = c_q;
                5'h0C:   s_dat_o = {8'h0, dims_q};
                5'h14:   s_dat_o = {8'h0, err_cnt_q, 7'h0, tmo_q, reject_q,
                                    (state_q != S_IDLE), empty, full, 4'(count_q)};
                5'h18:   s_dat_o = {16'h0, done_cnt_q};
                5'h1C:   s_dat_o = {30'h0, reject_q | tmo_q, irq_q};
                default: s_dat_o = 32'h0;
            endcase
        end
    end

    assign s_ack_o = ack_q;
    assign m_stb_o = stb_q;
    assign m_adr_o = stb_q ? bus_adr : 32'h0;
    assign m_dat_o = stb_q ? bus_dat : 32'h0;
    assign m_we_o  = stb_q && bus_we;
    assign irq     = irq_q;

endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Scoreboard bench for matrix_job_scheduler: expected accelerator transactions
// and CPU read data are queued as stimulus is issued; monitors pop and compare.
module tb_matrix_job_scheduler;

    localparam int FD = 4;
    localparam int MD = 8;
    localparam int PG = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_adr_i, s_dat_i, s_dat_o;
    logic        s_we_i, s_stb_i, s_ack_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic        m_we_o, m_stb_o;
    logic        m_ack_i = 1'b0;
    logic        irq;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    xact_t       exp_m[$];
    logic [31:0] exp_s[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_after = 0;
    int          model_polls = 0;

    matrix_job_scheduler #(
        .FIFO_DEPTH(FD), .MAX_DIM(MD), .POLL_GAP(PG), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_we_i(s_we_i), .s_stb_i(s_stb_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Accelerator model: ack one cycle after strobe; status reads report done
    // on poll number done_after (never when done_after is 0).
    always @(posedge clk) begin
        if (m_stb_o && !m_ack_i) begin
            m_ack_i <= 1'b1;
            if (!m_we_o && m_adr_o == 32'h16) begin
                model_polls <= model_polls + 1;
                m_dat_i <= (done_after != 0 && model_polls + 1 == done_after) ? 32'd2 : 32'd1;
            end else begin
                m_dat_i <= 32'h0;
                if (m_we_o && m_adr_o == 32'h0 && m_dat_o == 32'h1) model_polls <= 0;
            end
        end else begin
            m_ack_i <= 1'b0;
        end
    end

    // Master-side monitor.
    always @(negedge clk) begin
        if (m_stb_o && m_ack_i) begin
            n_vec++;
            if (exp_m.size() == 0) begin
                n_err++;
                $display("FAIL master_unexpected got we=%0b adr=%h dat=%h want none",
                         m_we_o, m_adr_o, m_dat_o);
            end else begin
                xact_t e;
                e = exp_m.pop_front();
                if (m_we_o !== e.we || m_adr_o !== e.adr || m_dat_o !== e.dat) begin
                    n_err++;
                    $display("FAIL master_xact got we=%0b adr=%h dat=%h want we=%0b adr=%h dat=%h",
                             m_we_o, m_adr_o, m_dat_o, e.we, e.adr, e.dat);
                end
            end
        end
    end

    // CPU read-data monitor.
    always @(negedge clk) begin
        if (s_ack_o && !s_we_i) begin
            n_vec++;
            if (exp_s.size() == 0) begin
                n_err++;
                $display("FAIL cpu_read_unexpected got %h adr=%h", s_dat_o, s_adr_i);
            end else begin
                logic [31:0] e;
                e = exp_s.pop_front();
                if (s_dat_o !== e) begin
                    n_err++;
                    $display("FAIL cpu_read adr=%h got %h want %h", s_adr_i, s_dat_o, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cpu_xfer(input bit now, input bit we, input logic [31:0] adr,
                            input logic [31:0] dat);
        bit got;
        if (!now) @(negedge clk);
        s_stb_i = 1'b1;
        s_we_i  = we;
        s_adr_i = adr;
        s_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        s_stb_i = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL cpu_ack_timeout adr=%h got no ack want ack", adr);
        end
    endtask

    task automatic cpu_write(input logic [31:0] adr, input logic [31:0] dat);
        cpu_xfer(1'b0, 1'b1, adr, dat);
    endtask

    task automatic cpu_read(input logic [31:0] adr, input logic [31:0] exp);
        exp_s.push_back(exp);
        cpu_xfer(1'b0, 1'b0, adr, 32'h0);
    endtask

    task automatic push_m(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        xact_t x;
        x.we  = we;
        x.adr = adr;
        x.dat = dat;
        exp_m.push_back(x);
    endtask

    task automatic expect_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [23:0] dims, input int npolls, input bit with_clear);
        push_m(1'b1, 32'h04, a);
        push_m(1'b1, 32'h08, b);
        push_m(1'b1, 32'h0C, c);
        push_m(1'b1, 32'h10, {24'h0, dims[7:0]});
        push_m(1'b1, 32'h12, {24'h0, dims[15:8]});
        push_m(1'b1, 32'h14, {24'h0, dims[23:16]});
        push_m(1'b1, 32'h00, 32'h1);
        for (int i = 0; i < npolls; i++) push_m(1'b0, 32'h16, 32'h0);
        if (with_clear) push_m(1'b1, 32'h00, 32'h0);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_m.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_m.size());
            exp_m.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic stage(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [23:0] dims);
        cpu_write(32'h00, a);
        cpu_write(32'h04, b);
        cpu_write(32'h08, c);
        cpu_write(32'h0C, {8'h0, dims});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        reset   = 1'b1;
        s_adr_i = 32'h0;
        s_dat_i = 32'h0;
        s_we_i  = 1'b0;
        s_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ack", {31'h0, s_ack_o}, 32'h0);
        check("rst_m_stb", {31'h0, m_stb_o}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_m_adr", m_adr_o, 32'h0);
        reset = 1'b0;
        cpu_read(32'h14, 32'h0000_0020);

        // Single job, done on the third poll.
        done_after = 3;
        stage(32'h1000, 32'h2000, 32'h3000, 24'h020202);
        expect_job(32'h1000, 32'h2000, 32'h3000, 24'h020202, 3, 1'b1);
        cpu_write(32'h10, 32'h0);
        drain();
        cpu_read(32'h18, 32'd1);
        cpu_read(32'h14, 32'h0000_0020);
        check("t1_irq", {31'h0, irq}, 32'h1);
        cpu_read(32'h1C, 32'h1);
        cpu_write(32'h1C, 32'h1);
        @(negedge clk);
        check("t1_irq_clr", {31'h0, irq}, 32'h0);

        // Five pushes into a four-deep queue while the first job runs.
        done_after = 1;
        stage(32'h10, 32'h20, 32'h30, 24'h030108);
        for (int j = 0; j < 4; j++) expect_job(32'h10, 32'h20, 32'h30, 24'h030108, 1, 1'b1);
        for (int j = 0; j < 5; j++) cpu_write(32'h10, 32'h0);
        cpu_read(32'h14, 32'h0000_00D4);
        drain();
        cpu_read(32'h18, 32'd5);
        cpu_read(32'h14, 32'h0000_00A0);
        cpu_write(32'h1C, 32'h3);
        cpu_read(32'h14, 32'h0000_0020);

        // Illegal dimensions are rejected without enqueue.
        cpu_write(32'h0C, 32'h0001_0109);
        cpu_write(32'h10, 32'h0);
        cpu_read(32'h14, 32'h0000_00A0);
        cpu_write(32'h1C, 32'h2);
        cpu_read(32'h14, 32'h0000_0020);
        cpu_write(32'h0C, 32'h0000_0101);
        cpu_read(32'h0C, 32'h0000_0101);
        cpu_write(32'h10, 32'h0);
        cpu_read(32'h14, 32'h0000_00A0);
        cpu_write(32'h1C, 32'h2);

        // Accelerator never finishes: exactly TO polls, then clear and retire.
        done_after = 0;
        cpu_write(32'h0C, 32'h0008_0808);
        expect_job(32'h10, 32'h20, 32'h30, 24'h080808, TO, 1'b1);
        cpu_write(32'h10, 32'h0);
        drain();
        cpu_read(32'h14, 32'h0001_0120);
        cpu_read(32'h18, 32'd5);
        check("t4_irq", {31'h0, irq}, 32'h1);
        cpu_write(32'h1C, 32'h3);
        cpu_read(32'h14, 32'h0001_0020);

        // Push landing in the retire cycle of the only queued job.
        done_after = 1;
        stage(32'hA0, 32'hB0, 32'hC0, 24'h030201);
        expect_job(32'hA0, 32'hB0, 32'hC0, 24'h030201, 1, 1'b1);
        cpu_write(32'h10, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_stb_o && m_ack_i && m_we_o && m_adr_o == 32'h0 && m_dat_o == 32'h0) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_clear_seen", {31'h0, hit}, 32'h1);
        if (hit) begin
            expect_job(32'hA0, 32'hB0, 32'hC0, 24'h030201, 1, 1'b1);
            cpu_xfer(1'b1, 1'b1, 32'h10, 32'h0);
            cpu_read(32'h14, 32'h0001_0041);
        end
        drain();
        cpu_read(32'h18, 32'd7);
        check("t5_irq", {31'h0, irq}, 32'h1);

        // Reset asserted while the first status poll is on the bus.
        done_after = 0;
        expect_job(32'hA0, 32'hB0, 32'hC0, 24'h030201, 0, 1'b0);
        cpu_write(32'h10, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (m_stb_o && !m_we_o && m_adr_o == 32'h16) begin
                hit = 1'b1;
                break;
            end
        end
        check("t6_poll_seen", {31'h0, hit}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_stb_drop", {31'h0, m_stb_o}, 32'h0);
        check("t6_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_stb_idle", {31'h0, m_stb_o}, 32'h0);
        cpu_read(32'h14, 32'h0000_0020);
        cpu_read(32'h18, 32'h0);
        repeat (2) @(negedge clk);
        check("pending_master", 32'(exp_m.size()), 32'h0);
        check("pending_cpu", 32'(exp_s.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
